// File: rtl/tlb_lookup_arbiter_pkg.sv
// Shared CPU definitions used by the TLB lookup arbiter: TLB result types,
// requester ids and the CP0 Index packing helper.
package tlb_lookup_arbiter_pkg;

  localparam int TLB_ENTRIES_NUM = 16;

  typedef logic [31:0] virt_t;
  typedef logic [$clog2(TLB_ENTRIES_NUM)-1:0] tlb_index_t;

  typedef struct packed {
    logic       miss;
    tlb_index_t which;
    logic [19:0] pfn;
    logic [2:0] c;
    logic       d;
    logic       v;
  } tlb_result_t;

  localparam logic [1:0] LK_REQ_NONE = 2'd0;
  localparam logic [1:0] LK_REQ_INST = 2'd1;
  localparam logic [1:0] LK_REQ_DATA = 2'd2;
  localparam logic [1:0] LK_REQ_TLBP = 2'd3;

  // CP0 Index layout: P bit on top, matching entry index in the low bits (zero on a miss).
  function automatic logic [31:0] make_tlbp_index(input tlb_result_t r);
    return {r.miss, 27'd0, (r.miss ? 4'd0 : r.which)};
  endfunction

endpackage

// File: rtl/tlb_lookup_arbiter_if.sv
// Requester, TLBP, write-strobe and TLB lookup-port signals of the lookup arbiter.
interface tlb_lookup_arbiter_if;
  import tlb_lookup_arbiter_pkg::*;

  logic        flush;
  logic [7:0]  asid;
  logic        inst_req;
  virt_t       inst_vaddr;
  logic        inst_ack;
  logic        inst_resp_valid;
  tlb_result_t inst_result;
  logic        data_req;
  virt_t       data_vaddr;
  logic        data_ack;
  logic        data_resp_valid;
  tlb_result_t data_result;
  logic        tlbp_req;
  logic [31:0] tlbp_entry_hi;
  logic        tlbp_ack;
  logic        tlbp_resp_valid;
  logic [31:0] tlbp_index;
  logic        tlb_we;
  logic        lk_valid;
  logic [18:0] lk_vpn2;
  logic        lk_odd;
  logic [7:0]  lk_asid;
  tlb_result_t lk_result;

  modport slave (
    input  flush, asid, inst_req, inst_vaddr, data_req, data_vaddr,
           tlbp_req, tlbp_entry_hi, tlb_we, lk_result,
    output inst_ack, inst_resp_valid, inst_result,
           data_ack, data_resp_valid, data_result,
           tlbp_ack, tlbp_resp_valid, tlbp_index,
           lk_valid, lk_vpn2, lk_odd, lk_asid
  );

  modport master (
    output flush, asid, inst_req, inst_vaddr, data_req, data_vaddr,
           tlbp_req, tlbp_entry_hi, tlb_we, lk_result,
    input  inst_ack, inst_resp_valid, inst_result,
           data_ack, data_resp_valid, data_result,
           tlbp_ack, tlbp_resp_valid, tlbp_index,
           lk_valid, lk_vpn2, lk_odd, lk_asid
  );

endinterface

// File: rtl/tlb_lookup_arbiter_prio.sv
// Combinational winner pick: TLBP first, then data, then fetch; a starved
// fetch overtakes data.
module tlb_arb_prio
  import tlb_lookup_arbiter_pkg::*;
(
  input  logic       inst_req_i,
  input  logic       data_req_i,
  input  logic       tlbp_req_i,
  input  logic       starved_i,
  output logic [1:0] id_o
);

  // Priority decode with the starvation override between inst and data.
  always_comb begin
    id_o = LK_REQ_NONE;
    if (tlbp_req_i) begin
      id_o = LK_REQ_TLBP;
    end else if (inst_req_i && (starved_i || !data_req_i)) begin
      id_o = LK_REQ_INST;
    end else if (data_req_i) begin
      id_o = LK_REQ_DATA;
    end else begin
      id_o = LK_REQ_NONE;
    end
  end

endmodule

// File: rtl/tlb_lookup_arbiter.sv
// Shares the single TLB lookup port between fetch, data and TLBP; returns the
// registered result to the granted requester one cycle after the grant.
module tlb_lookup_arbiter
  import tlb_lookup_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int WR_HOLD      = 1
) (
  input logic                 clk,
  input logic                 resetn,
  tlb_lookup_arbiter_if.slave bus
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam int HCW = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  logic [0:0]     state_q, state_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic [SCW-1:0] starve_q, starve_d;
  logic [1:0]     resp_id_q, resp_id_d;
  tlb_result_t    result_q, result_d;
  logic           grant_en_s;
  logic           starved_s;
  logic [1:0]     win_id_s;

  // The port is closed in the write cycle, during the post-write hold and while in reset.
  assign grant_en_s = resetn && !bus.tlb_we && (state_q == ST_RUN);
  assign starved_s  = (starve_q == SCW'(STARVE_LIMIT));

  tlb_arb_prio u_prio (
    .inst_req_i (grant_en_s && bus.inst_req && !bus.flush),
    .data_req_i (grant_en_s && bus.data_req && !bus.flush),
    .tlbp_req_i (grant_en_s && bus.tlbp_req),
    .starved_i  (starved_s),
    .id_o       (win_id_s)
  );

  assign bus.inst_ack = (win_id_s == LK_REQ_INST);
  assign bus.data_ack = (win_id_s == LK_REQ_DATA);
  assign bus.tlbp_ack = (win_id_s == LK_REQ_TLBP);
  assign bus.lk_valid = (win_id_s != LK_REQ_NONE);

  // Lookup-port mux; all fields read as zero when nothing is granted.
  always_comb begin
    bus.lk_vpn2 = 19'd0;
    bus.lk_odd  = 1'b0;
    bus.lk_asid = 8'd0;
    case (win_id_s)
      LK_REQ_INST: begin
        bus.lk_vpn2 = bus.inst_vaddr[31:13];
        bus.lk_odd  = bus.inst_vaddr[12];
        bus.lk_asid = bus.asid;
      end
      LK_REQ_DATA: begin
        bus.lk_vpn2 = bus.data_vaddr[31:13];
        bus.lk_odd  = bus.data_vaddr[12];
        bus.lk_asid = bus.asid;
      end
      LK_REQ_TLBP: begin
        bus.lk_vpn2 = bus.tlbp_entry_hi[31:13];
        bus.lk_odd  = 1'b0;
        bus.lk_asid = bus.tlbp_entry_hi[7:0];
      end
      default: begin
        bus.lk_vpn2 = 19'd0;
        bus.lk_odd  = 1'b0;
        bus.lk_asid = 8'd0;
      end
    endcase
  end

  // A flush landing on the response cycle kills inst/data results but not TLBP.
  assign bus.inst_resp_valid = (resp_id_q == LK_REQ_INST) && !bus.flush;
  assign bus.data_resp_valid = (resp_id_q == LK_REQ_DATA) && !bus.flush;
  assign bus.tlbp_resp_valid = (resp_id_q == LK_REQ_TLBP);
  assign bus.inst_result     = result_q;
  assign bus.data_result     = result_q;
  assign bus.tlbp_index      = make_tlbp_index(result_q);

  // Next-state for response stage, starvation counter and write-hold FSM.
  always_comb begin
    resp_id_d = win_id_s;
    result_d  = bus.lk_valid ? bus.lk_result : result_q;
    starve_d  = starve_q;
    state_d   = state_q;
    hold_d    = hold_q;

    if (!bus.inst_req || bus.inst_ack) begin
      starve_d = '0;
    end else if (bus.data_ack && !starved_s) begin
      starve_d = starve_q + SCW'(1);
    end else begin
      starve_d = starve_q;
    end

    case (state_q)
      ST_RUN: begin
        if (bus.tlb_we) begin
          state_d = ST_HOLD;
          hold_d  = HCW'(WR_HOLD - 1);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (bus.tlb_we) begin
          hold_d = HCW'(WR_HOLD - 1);
        end else if (hold_q == '0) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q - HCW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        hold_d  = '0;
      end
    endcase
  end

  // State registers; reset drops any result still in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_RUN;
      hold_q    <= '0;
      starve_q  <= '0;
      resp_id_q <= LK_REQ_NONE;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      starve_q  <= starve_d;
      resp_id_q <= resp_id_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// Self-checking bench for tlb_lookup_arbiter: grant-cycle checks in each test
// task, response checks through a scoreboard queue drained by a monitor.
module tb_tlb_lookup_arbiter;
  import tlb_lookup_arbiter_pkg::*;

  typedef struct {
    logic [1:0]  id;
    tlb_result_t res;
    int          due;
  } sb_t;

  logic        clk;
  logic        resetn;
  logic        tb_miss;
  logic [3:0]  tb_which;
  int          cyc;
  int          checks;
  int          errors;
  sb_t         sb_q[$];

  tlb_lookup_arbiter_if bus ();

  tlb_lookup_arbiter #(.STARVE_LIMIT(4), .WR_HOLD(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Bench TLB: result fields derived from the presented lookup
  function automatic tlb_result_t model_res(input logic [18:0] vpn2, input logic odd,
                                            input logic miss, input logic [3:0] which);
    tlb_result_t r;
    r.miss  = miss;
    r.which = which;
    r.pfn   = {vpn2, odd};
    r.c     = 3'd3;
    r.d     = odd;
    r.v     = !miss;
    return r;
  endfunction

  assign bus.lk_result = model_res(bus.lk_vpn2, bus.lk_odd, tb_miss, tb_which);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive_idle();
    bus.flush         = 1'b0;
    bus.asid          = 8'h00;
    bus.inst_req      = 1'b0;
    bus.inst_vaddr    = 32'h0;
    bus.data_req      = 1'b0;
    bus.data_vaddr    = 32'h0;
    bus.tlbp_req      = 1'b0;
    bus.tlbp_entry_hi = 32'h0;
    bus.tlb_we        = 1'b0;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [18:0] vpn2, input logic odd);
    sb_t e;
    e.id  = id;
    e.res = model_res(vpn2, odd, tb_miss, tb_which);
    e.due = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic sb_monitor();
    sb_t e;
    logic [31:0] exp_idx;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        checks++;
        if (bus.inst_resp_valid !== (e.id == LK_REQ_INST) ||
            bus.data_resp_valid !== (e.id == LK_REQ_DATA) ||
            bus.tlbp_resp_valid !== (e.id == LK_REQ_TLBP)) begin
          errors++;
          $display("FAIL sb_valid cyc=%0d got inst/data/tlbp=%b%b%b want id=%0d",
                   cyc, bus.inst_resp_valid, bus.data_resp_valid, bus.tlbp_resp_valid, e.id);
        end
        checks++;
        if (e.id == LK_REQ_TLBP) begin
          exp_idx = {e.res.miss, 27'd0, (e.res.miss ? 4'd0 : e.res.which)};
          if (bus.tlbp_index !== exp_idx) begin
            errors++;
            $display("FAIL sb_tlbp_index cyc=%0d got %h want %h", cyc, bus.tlbp_index, exp_idx);
          end
        end else if (e.id == LK_REQ_INST) begin
          if (bus.inst_result !== e.res) begin
            errors++;
            $display("FAIL sb_inst_result cyc=%0d got %h want %h", cyc, bus.inst_result, e.res);
          end
        end else begin
          if (bus.data_result !== e.res) begin
            errors++;
            $display("FAIL sb_data_result cyc=%0d got %h want %h", cyc, bus.data_result, e.res);
          end
        end
      end else begin
        checks++;
        if (bus.inst_resp_valid !== 1'b0 || bus.data_resp_valid !== 1'b0 ||
            bus.tlbp_resp_valid !== 1'b0) begin
          errors++;
          $display("FAIL sb_unexpected cyc=%0d got inst/data/tlbp=%b%b%b want 000",
                   cyc, bus.inst_resp_valid, bus.data_resp_valid, bus.tlbp_resp_valid);
        end
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive_idle();
    tb_miss  = 1'b0;
    tb_which = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.inst_ack, bus.data_ack, bus.tlbp_ack, bus.lk_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_acks got %b want 0000",
               {bus.inst_ack, bus.data_ack, bus.tlbp_ack, bus.lk_valid});
    end
    checks++;
    if (bus.tlbp_index !== 32'h0 || bus.inst_result !== '0 || bus.data_result !== '0) begin
      errors++;
      $display("FAIL reset_results got idx=%h inst=%h data=%h want 0",
               bus.tlbp_index, bus.inst_result, bus.data_result);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_inst_back_to_back();
    logic [31:0] va[3];
    va[0] = 32'h0040_1000;
    va[1] = 32'h7fff_e000;
    va[2] = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.asid       = 8'h2a + 8'(i);
      bus.inst_req   = 1'b1;
      bus.inst_vaddr = va[i];
      tb_which       = 4'd7 + 4'(i);
      @(negedge clk);
      checks++;
      if ({bus.inst_ack, bus.data_ack, bus.tlbp_ack, bus.lk_valid} !== 4'b1001) begin
        errors++;
        $display("FAIL inst_ack[%0d] got %b want 1001", i,
                 {bus.inst_ack, bus.data_ack, bus.tlbp_ack, bus.lk_valid});
      end
      checks++;
      if (bus.lk_vpn2 !== va[i][31:13] || bus.lk_odd !== va[i][12] ||
          bus.lk_asid !== 8'h2a + 8'(i)) begin
        errors++;
        $display("FAIL inst_lk[%0d] got vpn2=%h odd=%b asid=%h want %h %b %h", i,
                 bus.lk_vpn2, bus.lk_odd, bus.lk_asid, va[i][31:13], va[i][12], 8'h2a + 8'(i));
      end
      push_exp(LK_REQ_INST, va[i][31:13], va[i][12]);
    end
    // first address decodes to VPN2 0x00200, odd page
    checks++;
    if (va[0][31:13] !== 19'h00200) begin
      errors++;
      $display("FAIL inst_vpn2_decode got %h want 00200", va[0][31:13]);
    end
    @(posedge clk);
    #1 drive_idle();
  endtask

  task automatic test_starvation();
    logic exp_inst;
    @(posedge clk);
    #1;
    bus.asid       = 8'h3c;
    bus.inst_req   = 1'b1;
    bus.inst_vaddr = 32'h0000_2000;
    bus.data_req   = 1'b1;
    bus.data_vaddr = 32'h0000_5000;
    tb_which       = 4'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_inst = (i % 5 == 4);
      checks++;
      if (bus.inst_ack !== exp_inst || bus.data_ack !== !exp_inst) begin
        errors++;
        $display("FAIL starve[%0d] got inst_ack=%b data_ack=%b want %b %b", i,
                 bus.inst_ack, bus.data_ack, exp_inst, !exp_inst);
      end
      if (exp_inst) push_exp(LK_REQ_INST, 19'h00001, 1'b0);
      else          push_exp(LK_REQ_DATA, 19'h00002, 1'b1);
      @(posedge clk);
      #1;
    end
    drive_idle();
  endtask

  task automatic test_tlbp();
    @(posedge clk);
    #1;
    bus.asid          = 8'h11;
    bus.inst_req      = 1'b1;
    bus.inst_vaddr    = 32'h0000_4000;
    bus.data_req      = 1'b1;
    bus.data_vaddr    = 32'h0000_6000;
    bus.tlbp_req      = 1'b1;
    bus.tlbp_entry_hi = 32'h8000_2005;
    tb_miss           = 1'b0;
    tb_which          = 4'd3;
    @(negedge clk);
    checks++;
    if ({bus.tlbp_ack, bus.data_ack, bus.inst_ack} !== 3'b100) begin
      errors++;
      $display("FAIL tlbp_only got tlbp/data/inst=%b want 100",
               {bus.tlbp_ack, bus.data_ack, bus.inst_ack});
    end
    checks++;
    if (bus.lk_asid !== 8'h05 || bus.lk_vpn2 !== 19'h40001 || bus.lk_odd !== 1'b0) begin
      errors++;
      $display("FAIL tlbp_lk got asid=%h vpn2=%h odd=%b want 05 40001 0",
               bus.lk_asid, bus.lk_vpn2, bus.lk_odd);
    end
    push_exp(LK_REQ_TLBP, 19'h40001, 1'b0);
    @(posedge clk);
    #1;
    tb_miss  = 1'b1;
    tb_which = 4'd5;
    @(negedge clk);
    checks++;
    if (bus.tlbp_index !== 32'h0000_0003) begin
      errors++;
      $display("FAIL tlbp_hit_index got %h want 00000003", bus.tlbp_index);
    end
    push_exp(LK_REQ_TLBP, 19'h40001, 1'b0);
    @(posedge clk);
    #1;
    drive_idle();
    tb_miss = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.tlbp_index !== 32'h8000_0000) begin
      errors++;
      $display("FAIL tlbp_miss_index got %h want 80000000", bus.tlbp_index);
    end
  endtask

  task automatic test_write_hold();
    logic we_pat[7];
    logic ack_pat[7];
    we_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ack_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tb_which = 4'd9;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      bus.asid       = 8'h44;
      bus.inst_req   = 1'b1;
      bus.inst_vaddr = 32'h0040_3000;
      bus.tlb_we     = we_pat[i];
      @(negedge clk);
      checks++;
      if (bus.inst_ack !== ack_pat[i] || bus.lk_valid !== ack_pat[i]) begin
        errors++;
        $display("FAIL write_hold[%0d] got ack=%b lk_valid=%b want %b", i,
                 bus.inst_ack, bus.lk_valid, ack_pat[i]);
      end
      if (ack_pat[i]) push_exp(LK_REQ_INST, 19'h00201, 1'b1);
    end
    @(posedge clk);
    #1 drive_idle();
  endtask

  task automatic test_flush();
    @(posedge clk);
    #1;
    bus.data_req   = 1'b1;
    bus.data_vaddr = 32'h1000_0000;
    bus.inst_req   = 1'b1;
    bus.inst_vaddr = 32'h0000_8000;
    bus.flush      = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.inst_ack, bus.data_ack, bus.lk_valid} !== 3'b000) begin
      errors++;
      $display("FAIL flush_no_grant got inst/data/lk=%b want 000",
               {bus.inst_ack, bus.data_ack, bus.lk_valid});
    end
    @(posedge clk);
    #1;
    bus.inst_req = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.data_ack !== 1'b1) begin
      errors++;
      $display("FAIL flush_data_grant got %b want 1", bus.data_ack);
    end
    @(posedge clk);
    #1;
    bus.data_req      = 1'b0;
    bus.flush         = 1'b1;
    bus.tlbp_req      = 1'b1;
    bus.tlbp_entry_hi = 32'h0000_4077;
    tb_which          = 4'd12;
    @(negedge clk);
    checks++;
    if (bus.data_resp_valid !== 1'b0 || bus.tlbp_ack !== 1'b1) begin
      errors++;
      $display("FAIL flush_inflight got data_resp_valid=%b tlbp_ack=%b want 0 1",
               bus.data_resp_valid, bus.tlbp_ack);
    end
    push_exp(LK_REQ_TLBP, 19'h00002, 1'b0);
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
    checks++;
    if (bus.tlbp_resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_tlbp_resp got %b want 1", bus.tlbp_resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    bus.asid       = 8'h5a;
    bus.inst_req   = 1'b1;
    bus.inst_vaddr = 32'h0050_0000;
    @(negedge clk);
    checks++;
    if (bus.inst_ack !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_grant got %b want 1", bus.inst_ack);
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({bus.inst_ack, bus.lk_valid, bus.inst_resp_valid, bus.data_resp_valid,
         bus.tlbp_resp_valid} !== 5'b00000 || bus.lk_vpn2 !== 19'd0 ||
        bus.tlbp_index !== 32'h0 || bus.inst_result !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got ack/lk/rv=%b vpn2=%h idx=%h res=%h want 0",
               {bus.inst_ack, bus.lk_valid, bus.inst_resp_valid, bus.data_resp_valid,
                bus.tlbp_resp_valid}, bus.lk_vpn2, bus.tlbp_index, bus.inst_result);
    end
    drive_idle();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    fork
      sb_monitor();
    join_none
    test_reset();
    test_inst_back_to_back();
    test_starvation();
    test_tlbp();
    test_write_hold();
    test_flush();
    test_reset_mid();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drained got %0d pending want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
